// File: rtl/route_setting_controller.sv
// Route-setting/locking controller for the route ring: arbitrates requests, sets one route
// at a time against points detection, then carries each route through lock, occupancy and release.
module route_setting_controller #(
    parameter int                           N_ROUTES       = 8,
    parameter logic [N_ROUTES*N_ROUTES-1:0] CONFLICT_MASK  = 64'h41A0_5028_140A_0582,
    parameter logic [15:0]                  SET_TIMEOUT    = 16'd1000,
    parameter logic [15:0]                  RELEASE_CYCLES = 16'd200,
    parameter logic [15:0]                  CANCEL_CYCLES  = 16'd500
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_ROUTES-1:0] i_req,
    input  logic [N_ROUTES-1:0] i_cancel,
    input  logic [N_ROUTES-1:0] i_occ,
    input  logic [N_ROUTES-1:0] i_pts_ok,
    output logic [N_ROUTES-1:0] o_lock,
    output logic [N_ROUTES-1:0] o_proceed,
    output logic [N_ROUTES-1:0] o_fault,
    output logic                o_busy,
    output logic                o_setter_state
);

    localparam int IDX_W  = (N_ROUTES > 1) ? $clog2(N_ROUTES) : 1;
    localparam int SCAN_W = IDX_W + 1;

    typedef enum logic {
        S_IDLE,
        S_SET
    } setter_t;

    typedef enum logic [2:0] {
        R_FREE,
        R_SETTING,
        R_LOCKED,
        R_OCCUPIED,
        R_RELEASING
    } route_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] t);
        return (t == 16'hFFFF) ? t : t + 16'd1;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_ROUTES - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    setter_t               setter_state;
    setter_t               setter_next;
    logic [IDX_W-1:0]      cur;
    logic [IDX_W-1:0]      rr;
    logic [15:0]           set_timer;
    logic [N_ROUTES-1:0]   route_free;
    logic [N_ROUTES-1:0]   cand;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic [SCAN_W-1:0]     scan_idx;
    logic                  do_select;
    logic                  set_cancel;
    logic                  set_locked;
    logic                  set_timeout;

    assign o_busy         = (setter_state != S_IDLE);
    assign o_setter_state = setter_state;

    // Requests are levels sampled at scan time; cancels are single-cycle pulses.
    // Eligibility uses registered lock/fault state, so a route freed this cycle waits one scan.
    always_comb begin
        cand = '0;
        for (int r = 0; r < N_ROUTES; r++) begin
            cand[r] = i_req[r] && route_free[r] && !o_fault[r] &&
                      ((CONFLICT_MASK[r*N_ROUTES +: N_ROUTES] & o_lock) == '0);
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_ROUTES; k++) begin
            scan_idx = {1'b0, rr} + SCAN_W'(k);
            if (scan_idx >= SCAN_W'(N_ROUTES)) begin
                scan_idx = scan_idx - SCAN_W'(N_ROUTES);
            end
            if (!sel_found && cand[scan_idx[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        setter_next = setter_state;
        do_select   = 1'b0;
        set_cancel  = 1'b0;
        set_locked  = 1'b0;
        set_timeout = 1'b0;
        case (setter_state)
            S_IDLE: begin
                if (sel_found) begin
                    do_select   = 1'b1;
                    setter_next = S_SET;
                end
            end
            S_SET: begin
                if (i_cancel[cur]) begin
                    set_cancel  = 1'b1;
                    setter_next = S_IDLE;
                end else if (i_pts_ok[cur]) begin
                    set_locked  = 1'b1;
                    setter_next = S_IDLE;
                end else if (set_timer == SET_TIMEOUT - 16'd1) begin
                    set_timeout = 1'b1;
                    setter_next = S_IDLE;
                end
            end
            default: setter_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            setter_state <= S_IDLE;
            cur          <= '0;
            rr           <= '0;
            set_timer    <= '0;
        end else begin
            setter_state <= setter_next;
            if (do_select) begin
                cur       <= sel_idx;
                set_timer <= '0;
            end else if (setter_state == S_SET) begin
                set_timer <= sat_inc(set_timer);
            end
            if (set_locked || set_timeout) begin
                rr <= next_idx(cur);
            end
        end
    end

    for (genvar g = 0; g < N_ROUTES; g++) begin : g_route
        route_t      st;
        logic [15:0] timer;
        logic        pend;
        logic        proceed_q;
        logic        fault_q;
        logic        is_cur;

        assign is_cur        = (cur == IDX_W'(g));
        assign route_free[g] = (st == R_FREE);
        assign o_lock[g]     = (st != R_FREE);
        assign o_proceed[g]  = proceed_q;
        assign o_fault[g]    = fault_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                st        <= R_FREE;
                timer     <= '0;
                pend      <= 1'b0;
                proceed_q <= 1'b0;
                fault_q   <= 1'b0;
            end else begin
                if (set_timeout && is_cur) begin
                    fault_q <= 1'b1;
                end else if (i_cancel[g]) begin
                    fault_q <= 1'b0;
                end
                proceed_q <= 1'b0;
                case (st)
                    R_FREE: begin
                        if (do_select && sel_idx == IDX_W'(g)) begin
                            st    <= R_SETTING;
                            timer <= '0;
                        end
                    end
                    R_SETTING: begin
                        if (is_cur && (set_cancel || set_timeout)) begin
                            st    <= R_FREE;
                            timer <= '0;
                        end else if (is_cur && set_locked) begin
                            st        <= R_LOCKED;
                            timer     <= '0;
                            pend      <= 1'b0;
                            proceed_q <= 1'b1;
                        end
                    end
                    R_LOCKED: begin
                        // Occupancy beats a cancel, including one already counting down.
                        if (i_occ[g]) begin
                            st    <= R_OCCUPIED;
                            timer <= '0;
                            pend  <= 1'b0;
                        end else if (pend) begin
                            if (timer == CANCEL_CYCLES - 16'd1) begin
                                st    <= R_FREE;
                                timer <= '0;
                                pend  <= 1'b0;
                            end else begin
                                timer <= sat_inc(timer);
                            end
                        end else if (i_cancel[g]) begin
                            pend  <= 1'b1;
                            timer <= '0;
                        end else begin
                            proceed_q <= i_pts_ok[g];
                        end
                    end
                    R_OCCUPIED: begin
                        if (!i_occ[g]) begin
                            st    <= R_RELEASING;
                            timer <= '0;
                        end
                    end
                    R_RELEASING: begin
                        if (i_occ[g]) begin
                            st    <= R_OCCUPIED;
                            timer <= '0;
                        end else if (timer == RELEASE_CYCLES - 16'd1) begin
                            st    <= R_FREE;
                            timer <= '0;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                    default: begin
                        st    <= R_FREE;
                        timer <= '0;
                        pend  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_route_setting_controller.sv
// Bench for route_setting_controller: an event/deadline reference model of the route ring,
// compared every cycle, plus pinned values at the key moments of each scenario.
module tb_route_setting_controller;

    localparam int T_SET = 1000;
    localparam int T_REL = 200;
    localparam int T_CAN = 500;
    localparam int FREE = 0, SETTING = 1, LOCKED = 2, OCCUPIED = 3, RELEASING = 4;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_req;
    logic [7:0] i_cancel;
    logic [7:0] i_occ;
    logic [7:0] i_pts_ok;
    logic [7:0] o_lock;
    logic [7:0] o_proceed;
    logic [7:0] o_fault;
    logic       o_busy;
    logic       o_setter_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // Reference model: route phases plus the absolute edge number at which a timed phase ends.
    int  m_st[8];
    bit  m_pend[8];
    int  m_dl[8];
    bit  m_fault[8];
    bit  m_proc[8];
    int  m_cur = -1;
    int  m_rr = 0;
    int  m_sdl = 0;
    logic [24:0] exp_q[$];

    route_setting_controller dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_cancel       (i_cancel),
        .i_occ          (i_occ),
        .i_pts_ok       (i_pts_ok),
        .o_lock         (o_lock),
        .o_proceed      (o_proceed),
        .o_fault        (o_fault),
        .o_busy         (o_busy),
        .o_setter_state (o_setter_state)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic model_step();
        int nst[8];
        bit npend[8];
        int ndl[8];
        bit nfault[8];
        int ncur, nrr, nsdl, r;
        bit found, busy;
        logic [7:0] l, p, f;
        cyc++;
        if (i_rst) begin
            for (int k = 0; k < 8; k++) begin
                m_st[k] = FREE; m_pend[k] = 0; m_dl[k] = 0; m_fault[k] = 0; m_proc[k] = 0;
            end
            m_cur = -1; m_rr = 0; m_sdl = 0;
        end else begin
            nst = m_st; npend = m_pend; ndl = m_dl; nfault = m_fault;
            ncur = m_cur; nrr = m_rr; nsdl = m_sdl;
            for (int k = 0; k < 8; k++) if (i_cancel[k]) nfault[k] = 0;
            if (m_cur < 0) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    r = (m_rr + k) % 8;
                    if (!found && i_req[r] && m_st[r] == FREE && !m_fault[r] &&
                        m_st[(r + 1) % 8] == FREE && m_st[(r + 7) % 8] == FREE) begin
                        found = 1; ncur = r; nst[r] = SETTING; nsdl = cyc + T_SET;
                    end
                end
            end else begin
                r = m_cur;
                if (i_cancel[r]) begin
                    nst[r] = FREE; ncur = -1;
                end else if (i_pts_ok[r]) begin
                    nst[r] = LOCKED; npend[r] = 0; ncur = -1; nrr = (r + 1) % 8;
                end else if (cyc == m_sdl) begin
                    nst[r] = FREE; nfault[r] = 1; ncur = -1; nrr = (r + 1) % 8;
                end
            end
            for (int k = 0; k < 8; k++) begin
                case (m_st[k])
                    LOCKED: begin
                        if (i_occ[k]) begin
                            nst[k] = OCCUPIED; npend[k] = 0;
                        end else if (m_pend[k]) begin
                            if (cyc == m_dl[k]) begin nst[k] = FREE; npend[k] = 0; end
                        end else if (i_cancel[k]) begin
                            npend[k] = 1; ndl[k] = cyc + T_CAN;
                        end
                    end
                    OCCUPIED: if (!i_occ[k]) begin nst[k] = RELEASING; ndl[k] = cyc + T_REL; end
                    RELEASING: begin
                        if (i_occ[k]) nst[k] = OCCUPIED;
                        else if (cyc == m_dl[k]) nst[k] = FREE;
                    end
                    default: ;
                endcase
            end
            for (int k = 0; k < 8; k++) m_proc[k] = (nst[k] == LOCKED) && !npend[k] && i_pts_ok[k];
            m_st = nst; m_pend = npend; m_dl = ndl; m_fault = nfault;
            m_cur = ncur; m_rr = nrr; m_sdl = nsdl;
        end
        for (int k = 0; k < 8; k++) begin
            l[k] = (m_st[k] != FREE);
            p[k] = m_proc[k];
            f[k] = m_fault[k];
        end
        busy = (m_cur >= 0);
        exp_q.push_back({l, p, f, busy});
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] got, exp_v;
        for (int c = 0; c < 4; c++) begin
            i_rst = (c < 2);
            i_req = (c < 2) ? 8'($urandom) : 8'h00;
            i_cancel = 8'h00; i_occ = 8'h00; i_pts_ok = 8'hFF;
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            vec_cnt++;
            if (got !== 25'd0) begin
                err_cnt++; $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, got);
            end
        end
    endtask

    task automatic test_single();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 5; c++) begin
            i_rst = (c == 0);
            i_req = (c >= 1) ? 8'h01 : 8'h00;
            i_cancel = 8'h00; i_occ = 8'h00; i_pts_ok = 8'hFF;
            pin = '0; pin_on = 1'b1;
            case (c)
                1:       pin = {8'h01, 8'h00, 8'h00, 1'b1};
                2, 4:    pin = {8'h01, 8'h01, 8'h00, 1'b0};
                default: pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL single_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_conflict();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 513; c++) begin
            i_rst = (c == 0);
            i_req = (c == 0) ? 8'h00 : (c < 3) ? 8'h01 : 8'h06;
            i_cancel = (c == 10) ? 8'h05 : 8'h00;
            i_occ = 8'h00; i_pts_ok = 8'hFF;
            pin = '0; pin_on = 1'b1;
            case (c)
                2:       pin = {8'h01, 8'h01, 8'h00, 1'b0};
                3:       pin = {8'h05, 8'h01, 8'h00, 1'b1};
                4, 9:    pin = {8'h05, 8'h05, 8'h00, 1'b0};
                10, 509: pin = {8'h05, 8'h00, 8'h00, 1'b0};
                510:     pin = {8'h00, 8'h00, 8'h00, 1'b0};
                511:     pin = {8'h02, 8'h00, 8'h00, 1'b1};
                512:     pin = {8'h02, 8'h02, 8'h00, 1'b0};
                default: pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL conflict_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL conflict_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 1006; c++) begin
            i_rst = (c == 0);
            i_req = (c == 0 || c == 1005) ? 8'h00 : 8'h08;
            i_cancel = (c == 1003 || c == 1005) ? 8'h08 : 8'h00;
            i_occ = 8'h00; i_pts_ok = 8'hF7;
            pin = '0; pin_on = 1'b1;
            case (c)
                1, 1000, 1004: pin = {8'h00 | 8'h08, 8'h00, 8'h00, 1'b1};
                1001, 1002:    pin = {8'h00, 8'h00, 8'h08, 1'b0};
                1003, 1005:    pin = {8'h00, 8'h00, 8'h00, 1'b0};
                default:       pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL timeout_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_release();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 207; c++) begin
            i_rst = (c == 0);
            i_req = (c == 1 || c == 2) ? 8'h01 : 8'h00;
            i_cancel = 8'h00;
            i_occ = (c >= 3 && c <= 5) ? 8'h01 : 8'h00;
            i_pts_ok = 8'hFF;
            pin = '0; pin_on = 1'b1;
            case (c)
                2:         pin = {8'h01, 8'h01, 8'h00, 1'b0};
                3, 6, 205: pin = {8'h01, 8'h00, 8'h00, 1'b0};
                206:       pin = {8'h00, 8'h00, 8'h00, 1'b0};
                default:   pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL release_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL release_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_cancel_occ();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 709; c++) begin
            i_rst = (c == 0);
            i_req = (c == 1 || c == 2 || c == 206 || c == 207) ? 8'h01 : 8'h00;
            i_cancel = (c == 3 || c == 4 || c == 208) ? 8'h01 : 8'h00;
            i_occ = (c == 3 || c == 4) ? 8'h01 : 8'h00;
            i_pts_ok = 8'hFF;
            pin = '0; pin_on = 1'b1;
            case (c)
                3, 4, 204, 208, 707: pin = {8'h01, 8'h00, 8'h00, 1'b0};
                205, 708:            pin = {8'h00, 8'h00, 8'h00, 1'b0};
                206:                 pin = {8'h01, 8'h00, 8'h00, 1'b1};
                207:                 pin = {8'h01, 8'h01, 8'h00, 1'b0};
                default:             pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL cancel_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL cancel_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_pts_loss();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 6; c++) begin
            i_rst = (c == 0);
            i_req = (c == 1 || c == 2) ? 8'h01 : 8'h00;
            i_cancel = 8'h00; i_occ = 8'h00;
            i_pts_ok = (c == 3 || c == 4) ? 8'hFE : 8'hFF;
            pin = '0; pin_on = 1'b1;
            case (c)
                3, 4:    pin = {8'h01, 8'h00, 8'h00, 1'b0};
                5:       pin = {8'h01, 8'h01, 8'h00, 1'b0};
                default: pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL pts_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL pts_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] got, exp_v, pin;
        bit pin_on;
        for (int c = 0; c < 8; c++) begin
            i_rst = (c == 0 || c == 7);
            i_req = (c == 0) ? 8'h00 : 8'h15;
            i_cancel = 8'h00; i_occ = 8'h00; i_pts_ok = 8'h05;
            pin = '0; pin_on = 1'b1;
            case (c)
                6:       pin = {8'h15, 8'h05, 8'h00, 1'b1};
                7:       pin = {8'h00, 8'h00, 8'h00, 1'b0};
                default: pin_on = 1'b0;
            endcase
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
            if (pin_on) begin
                vec_cnt++;
                if (got !== pin) begin
                    err_cnt++; $display("FAIL rstmid_pin c=%0d got=%h exp=%h", c, got, pin);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] got, exp_v;
        i_occ = 8'h00; i_pts_ok = 8'hFF;
        for (int c = 0; c < 20000; c++) begin
            i_rst = (c == 0) || ($urandom_range(0, 4999) == 0);
            for (int b = 0; b < 8; b++) begin
                i_req[b]    = ($urandom_range(0, 3) == 0);
                i_cancel[b] = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 149) == 0) i_occ[b] = ~i_occ[b];
                if (i_pts_ok[b]) begin
                    if ($urandom_range(0, 199) == 0) i_pts_ok[b] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    i_pts_ok[b] = 1'b1;
                end
            end
            tick();
            got = {o_lock, o_proceed, o_fault, o_busy};
            exp_v = exp_q.pop_front();
            vec_cnt++;
            if (got !== exp_v) begin
                err_cnt++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, got, exp_v);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_req = 8'h00; i_cancel = 8'h00; i_occ = 8'h00; i_pts_ok = 8'h00;
        test_reset();
        test_single();
        test_conflict();
        test_timeout();
        test_release();
        test_cancel_occ();
        test_pts_loss();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
